// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer : multi-cycle control FSM for ALU-class instructions
// Revision: 1.0
// ============================================================================
module alu_op_sequencer #(
  parameter int MULDIV_WAIT = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       sel_ra,
  output logic       sel_rb,
  output logic       c_out,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlo_out,
  output logic       Zhi_out,
  output logic       Rin,
  output logic       LOin,
  output logic       HIin,
  output logic [4:0] alu_op
);

  localparam logic [4:0] OP_NOP    = 5'b11001;
  localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT);

  generate
    if ((MULDIV_WAIT < 0) || (MULDIV_WAIT > 15)) begin : g_wait_range_check
      $error("alu_op_sequencer: MULDIV_WAIT must be within 0..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T_Y   = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_WB_LO = 3'd4,
    S_WB_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_op, w_op_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_illegal, w_illegal_nxt;

  function automatic logic is_binary(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd10);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op >= 5'd11) && (op <= 5'd13);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd15);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == 5'd16) || (op == 5'd17);
  endfunction

  logic w_in_legal, w_in_unary, w_op_imm, w_op_muldiv;

  assign w_in_unary  = is_unary(opcode);
  assign w_in_legal  = is_binary(opcode) || is_imm(opcode) ||
                       is_muldiv(opcode) || w_in_unary;
  assign w_op_imm    = is_imm(r_op);
  assign w_op_muldiv = is_muldiv(r_op);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NOP;
      r_cnt     <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_cnt     <= w_cnt_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Opcode/start are only looked at in IDLE; later states use the latched copy.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_cnt_nxt     = r_cnt;
    w_illegal_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_in_legal) begin
            w_op_nxt    = opcode;
            w_state_nxt = w_in_unary ? S_EXEC : S_T_Y;
          end else begin
            w_illegal_nxt = 1'b1;
          end
        end
      end
      S_T_Y: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_op_muldiv && (WAIT_LOAD != 4'd0)) begin
          w_cnt_nxt   = WAIT_LOAD;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_WB_LO;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_WB_LO;
        end
      end
      S_WB_LO: w_state_nxt = w_op_muldiv ? S_WB_HI : S_DONE;
      S_WB_HI: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    illegal = r_illegal;
    sel_ra  = 1'b0;
    sel_rb  = 1'b0;
    c_out   = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    Rin     = 1'b0;
    LOin    = 1'b0;
    HIin    = 1'b0;
    alu_op  = OP_NOP;
    if (r_state != S_IDLE) begin
      busy   = 1'b1;
      alu_op = r_op;
    end
    case (r_state)
      S_T_Y: begin
        sel_ra = 1'b1;
        Yin    = 1'b1;
      end
      S_EXEC, S_WAIT: begin
        Zin = 1'b1;
        if (w_op_imm) c_out  = 1'b1;
        else          sel_rb = 1'b1;
      end
      S_WB_LO: begin
        Zlo_out = 1'b1;
        if (w_op_muldiv) LOin = 1'b1;
        else             Rin  = 1'b1;
      end
      S_WB_HI: begin
        Zhi_out = 1'b1;
        HIin    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// Bench for alu_op_sequencer: two instances (MULDIV_WAIT=2 and 0) driven in lockstep,
// expected per-cycle output words queued at stimulus time and compared every cycle.
module tb_alu_op_sequencer;

  typedef logic [17:0] word_t;
  localparam word_t F_BUSY = 18'h20000;
  localparam word_t F_DONE = 18'h10000;
  localparam word_t F_ILL  = 18'h08000;
  localparam word_t F_RA   = 18'h04000;
  localparam word_t F_RB   = 18'h02000;
  localparam word_t F_C    = 18'h01000;
  localparam word_t F_YIN  = 18'h00800;
  localparam word_t F_ZIN  = 18'h00400;
  localparam word_t F_ZLO  = 18'h00200;
  localparam word_t F_ZHI  = 18'h00100;
  localparam word_t F_RIN  = 18'h00080;
  localparam word_t F_LO   = 18'h00040;
  localparam word_t F_HI   = 18'h00020;
  localparam word_t IDLE_W = 18'h00019;

  typedef struct {
    logic [4:0] op;
    int         d2;
    int         d0;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, start2, start0;
  logic [4:0] opcode;

  logic busy2, done2, ill2, ra2, rb2, c2, yin2, zin2, zlo2, zhi2, rin2, lo2, hi2;
  logic busy0, done0, ill0, ra0, rb0, c0, yin0, zin0, zlo0, zhi0, rin0, lo0, hi0;
  logic [4:0] aop2, aop0;
  word_t obs2, obs0;

  assign obs2 = {busy2, done2, ill2, ra2, rb2, c2, yin2, zin2, zlo2, zhi2, rin2, lo2, hi2, aop2};
  assign obs0 = {busy0, done0, ill0, ra0, rb0, c0, yin0, zin0, zlo0, zhi0, rin0, lo0, hi0, aop0};

  alu_op_sequencer #(.MULDIV_WAIT(2)) u_w2 (
    .clk(clk), .clear(clear), .start(start2), .opcode(opcode),
    .busy(busy2), .done(done2), .illegal(ill2), .sel_ra(ra2), .sel_rb(rb2), .c_out(c2),
    .Yin(yin2), .Zin(zin2), .Zlo_out(zlo2), .Zhi_out(zhi2), .Rin(rin2), .LOin(lo2),
    .HIin(hi2), .alu_op(aop2)
  );

  alu_op_sequencer #(.MULDIV_WAIT(0)) u_w0 (
    .clk(clk), .clear(clear), .start(start0), .opcode(opcode),
    .busy(busy0), .done(done0), .illegal(ill0), .sel_ra(ra0), .sel_rb(rb0), .c_out(c0),
    .Yin(yin0), .Zin(zin0), .Zlo_out(zlo0), .Zhi_out(zhi0), .Rin(rin0), .LOin(lo0),
    .HIin(hi0), .alu_op(aop0)
  );

  int    checks   = 0;
  int    failures = 0;
  word_t q2[$];
  word_t q0[$];

  task automatic check_w(input string name, input int cyc, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%05h expected=%05h", name, cyc, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void push_tr(input bit w2, input word_t v);
    if (w2) q2.push_back(v);
    else    q0.push_back(v);
  endfunction

  // Expected cycle-by-cycle outputs starting at cycle 1 after the accepting edge.
  function automatic void build_trace(input bit w2, input logic [4:0] op, input int w);
    bit    bin, imm, md, un;
    word_t o, ex;
    bin = (op >= 5'd3) && (op <= 5'd10);
    imm = (op >= 5'd11) && (op <= 5'd13);
    md  = (op == 5'd14) || (op == 5'd15);
    un  = (op == 5'd16) || (op == 5'd17);
    o   = {13'b0, op};
    if (!(bin || imm || md || un)) begin
      push_tr(w2, F_ILL | IDLE_W);
      push_tr(w2, IDLE_W);
      return;
    end
    if (!un) push_tr(w2, F_BUSY | F_RA | F_YIN | o);
    ex = F_BUSY | F_ZIN | (imm ? F_C : F_RB) | o;
    push_tr(w2, ex);
    if (md) begin
      for (int k = 0; k < w; k++) push_tr(w2, ex);
      push_tr(w2, F_BUSY | F_ZLO | F_LO | o);
      push_tr(w2, F_BUSY | F_ZHI | F_HI | o);
    end else begin
      push_tr(w2, F_BUSY | F_ZLO | F_RIN | o);
    end
    push_tr(w2, F_BUSY | F_DONE | o);
    push_tr(w2, IDLE_W);
  endfunction

  task automatic run_op(input logic [4:0] op, input int exp_d2, input int exp_d0,
                        input bit interfere, input int clear_at);
    int    cyc, d2, d0;
    word_t e2, e0;
    cyc = 0; d2 = 0; d0 = 0;
    @(negedge clk);
    opcode = op; start2 = 1'b1; start0 = 1'b1;
    build_trace(1'b1, op, 2);
    build_trace(1'b0, op, 0);
    @(posedge clk); #1;
    start2 = 1'b0; start0 = 1'b0;
    while ((q2.size() != 0 || q0.size() != 0) && cyc < 60) begin
      cyc++;
      e2 = (q2.size() != 0) ? q2.pop_front() : IDLE_W;
      e0 = (q0.size() != 0) ? q0.pop_front() : IDLE_W;
      check_w("out_w2", cyc, obs2, e2);
      check_w("out_w0", cyc, obs0, e0);
      if (obs2[16]) d2 = cyc;
      if (obs0[16]) d0 = cyc;
      if (interfere) begin
        opcode = 5'b00100;
        start2 = e2[17];
        start0 = e0[17];
      end
      if (cyc == clear_at) begin
        #2 clear = 1'b0;
        #1;
        check_w("clear_async_w2", cyc, obs2, IDLE_W);
        check_w("clear_async_w0", cyc, obs0, IDLE_W);
        q2.delete(); q0.delete();
        repeat (3) begin
          q2.push_back(IDLE_W);
          q0.push_back(IDLE_W);
        end
        @(negedge clk);
        clear = 1'b1;
      end
      if (q2.size() != 0 || q0.size() != 0) begin
        @(posedge clk); #1;
      end
    end
    check_i("drain_bound", q2.size() + q0.size(), 0);
    check_i("done_cycle_w2", d2, exp_d2);
    check_i("done_cycle_w0", d0, exp_d0);
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{5'b00011, 4, 4};
    tbl[1]  = '{5'b00100, 4, 4};
    tbl[2]  = '{5'b00101, 4, 4};
    tbl[3]  = '{5'b00110, 4, 4};
    tbl[4]  = '{5'b00111, 4, 4};
    tbl[5]  = '{5'b01000, 4, 4};
    tbl[6]  = '{5'b01001, 4, 4};
    tbl[7]  = '{5'b01010, 4, 4};
    tbl[8]  = '{5'b01011, 4, 4};
    tbl[9]  = '{5'b01100, 4, 4};
    tbl[10] = '{5'b01101, 4, 4};
    tbl[11] = '{5'b01110, 7, 5};
    tbl[12] = '{5'b01111, 7, 5};
    tbl[13] = '{5'b10000, 3, 3};
    tbl[14] = '{5'b10001, 3, 3};
    tbl[15] = '{5'b00000, 0, 0};
    tbl[16] = '{5'b00010, 0, 0};
    tbl[17] = '{5'b10010, 0, 0};
    tbl[18] = '{5'b11010, 0, 0};
    tbl[19] = '{5'b11001, 0, 0};
    tbl[20] = '{5'b11111, 0, 0};

    clear = 1'b0; start2 = 1'b0; start0 = 1'b0; opcode = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    check_w("reset_w2", 0, obs2, IDLE_W);
    check_w("reset_w0", 0, obs0, IDLE_W);
    @(negedge clk);
    clear = 1'b1;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].d2, tbl[i].d0, 1'b0, 0);

    // div with opcode toggled and start pulsed on every busy cycle, DONE included
    run_op(5'b01111, 7, 5, 1'b1, 0);
    // clear in WB_LO of mul (cycle 5 on the MULDIV_WAIT=2 instance)
    run_op(5'b01110, 0, 5, 1'b0, 5);
    run_op(5'b00011, 4, 4, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control sequencer for the single-bus datapath's ALU-class instructions. On a start pulse it latches the 5-bit opcode and walks the register file, Y register, ALU and 64-bit Z register through operand load, execute and write-back. Mul/div results go to HI/LO, with a programmable settle interval for the combinational multiplier/divider. It sits between the main instruction-decode FSM, which hands off ALU instructions, and the datapath enable/select lines.

## Interface
- MULDIV_WAIT, 2: extra EXEC cycles (Zin held) for multiply/divide; legal range 0–15.
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- opcode  in  5  instruction opcode; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse: start with a non-ALU opcode.
- sel_ra  out  1  drive Ra register field onto bus.
- sel_rb  out  1  drive Rb register field onto bus.
- c_out  out  1  drive sign-extended immediate onto bus.
- Yin  out  1  load Y from bus.
- Zin  out  1  load Z from ALU result.
- Zlo_out  out  1  drive Z[31:0] onto bus.
- Zhi_out  out  1  drive Z[63:32] onto bus.
- Rin  out  1  write bus into Rc field register.
- LOin  out  1  load LO from bus.
- HIin  out  1  load HI from bus.
- alu_op  out  5  opcode presented to ALU.

## Operation
- Legal opcodes:
  - binary: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - immediate: addi 01011, andi 01100, ori 01101.
  - mul/div: mul 01110, div 01111.
  - unary: neg 10000, not 10001.
- All other codes are illegal, including 00000–00010, 10010–11111, nop and halt.
- States and transitions:
  - IDLE:
    - start=1 with a legal opcode: latch opcode; go to T_Y if binary/immediate/muldiv, otherwise EXEC.
    - start=1 with an illegal opcode: pulse illegal, stay in IDLE.
    - start=0: stay.
  - T_Y: sel_ra=1, Yin=1 → EXEC.
  - EXEC: operand select and Zin=1.
    - immediate ops: c_out=1; all others: sel_rb=1.
    - mul/div with MULDIV_WAIT>0: load counter with MULDIV_WAIT → WAIT.
    - otherwise → WB_LO.
  - WAIT: same outputs as EXEC; counter decrements each cycle; at counter==1 → WB_LO.
  - WB_LO: Zlo_out=1.
    - mul/div: LOin=1 → WB_HI.
    - others: Rin=1 → DONE.
  - WB_HI: Zhi_out=1, HIin=1 → DONE.
  - DONE: done=1 → IDLE.
- All outputs are Moore, decoded from registered state; no combinational path from start or opcode to any control line.
- alu_op:
  - latched opcode from T_Y through DONE, and in EXEC when T_Y is skipped.
  - 11001 (nop) in IDLE.
- Latched opcode is stable for the whole operation; changes on the opcode input while busy have no effect.
- start while busy, including in DONE, is ignored and never queued.
- Enables within a state are mutually exclusive:
  - never sel_ra with sel_rb or c_out;
  - never Zlo_out with Zhi_out.

## Timing
- Accepting edge = rising edge at which IDLE samples start=1.
- Cycles after the accepting edge:
  - binary/immediate: T_Y(1), EXEC(2), WB_LO(3), DONE(4); done in cycle 4.
  - unary: EXEC(1), WB_LO(2), DONE(3).
  - mul/div: T_Y(1), EXEC(2), WAIT(3..2+W), WB_LO(3+W), WB_HI(4+W), DONE(5+W); default done in cycle 7.
- MULDIV_WAIT=0: mul/div goes EXEC→WB_LO; done in cycle 5.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after DONE.
- illegal is asserted in the cycle after the sampling edge, for exactly one cycle.
- clear low at any time, including mid-WAIT or WB_HI:
  - immediately forces IDLE;
  - counter=0, latched opcode=11001;
  - all outputs 0 except alu_op=11001.
  - No partial write-back completes after clear.
- Reset values: busy, done, illegal, all enables = 0; alu_op = 11001.

## Test plan
- Reset, then start with add (00011): Yin at cycle 1; Zin+sel_rb, alu_op=00011 at cycle 2; Zlo_out+Rin at cycle 3; done at cycle 4; busy high for cycles 1–4.
- Start with addi (01011): EXEC has c_out=1, sel_rb=0. Start with not (10001): no Yin; done at cycle 3.
- Start with mul, MULDIV_WAIT=2: Zin high in cycles 2–4; LOin+Zlo_out at 5; HIin+Zhi_out at 6; done at 7. Repeat with MULDIV_WAIT=0: done at 5.
- Start with 10010 (branch) and with 11010 (halt): illegal pulses once; busy stays 0; no enable ever asserted.
- During a div, toggle opcode to 00100 and pulse start in WAIT and DONE: alu_op stays 01111; no second operation runs.
- Assert clear low in WB_LO of a mul (MULDIV_WAIT=2, cycle 5): HIin never asserts; outputs go to reset values asynchronously; a new add afterwards completes normally in 4 cycles.
